uart_rx_deframer: RTL and testbench

//   Receives 8N1 asynchronous serial data on the board UART_RX pin and delivers whole bytes
//   to the pipelined CPU's peripheral bus as a one-entry buffered register with valid/ack handshake.

---
 rtl/uart_rx_deframer.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 serial receiver with a one-entry byte buffer for the
// CPU peripheral bus. Samples the synchronised line at mid-bit, flags bad
// stop bits and bytes overwritten before the CPU consumed them.
//
// Handshake: rx_valid=1 means rx_data holds a byte the CPU has not consumed.
// The CPU pulses rx_ack for one clock to consume it. rx_ack is ignored while
// rx_valid=0. A new byte arriving while rx_valid=1 without a same-clock
// rx_ack sets the sticky rx_overrun flag, which the next rx_ack clears.
module uart_rx_deframer #(
   parameter int CLK_FREQ = 10_000_000,
   parameter int BAUD     = 9_600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       UART_RX,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       frame_err,
   output logic       busy,
   output logic [2:0] state_dbg
);

   // BIT_CLKS must be at least 8 for the half-bit start check to make sense.
   localparam int BIT_CLKS  = CLK_FREQ / BAUD;
   localparam int HALF_CLKS = BIT_CLKS / 2;
   localparam int CNT_W     = $clog2(BIT_CLKS);
   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CLKS - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CLKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             sync1;
   logic             sync2;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bitn;
   logic [7:0]       shreg;
   logic             cnt_clr;
   logic             take_bit;
   logic             deliver;
   logic             ferr_set;

   assign rx_s      = sync2;
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Two-flop synchroniser; idles high so reset does not look like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= UART_RX;
         sync2 <= sync1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-clock strobes for counter, shifter and outputs.
   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      take_bit   = 1'b0;
      deliver    = 1'b0;
      ferr_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) begin
               state_next = ST_START;
            end
         end
         ST_START: begin
            // Half a bit in: a line that is high again was only a glitch.
            if (cnt == CNT_HALF_END) begin
               cnt_clr    = 1'b1;
               state_next = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == CNT_BIT_END) begin
               cnt_clr  = 1'b1;
               take_bit = 1'b1;
               if (bitn == 3'd7) begin
                  state_next = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (cnt == CNT_BIT_END) begin
               cnt_clr = 1'b1;
               if (rx_s) begin
                  deliver    = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A line held low must go idle before another frame can start.
            cnt_clr = 1'b1;
            if (rx_s) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            cnt_clr    = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Bit-period clock counter; restarts on every state change and each data bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Data bit index and LSB-first shift register (new bits enter at the MSB).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitn  <= 3'd0;
         shreg <= 8'h00;
      end else begin
         if (state != ST_DATA) begin
            bitn <= 3'd0;
         end else if (take_bit) begin
            bitn <= bitn + 3'd1;
         end
         if (take_bit) begin
            shreg <= {rx_s, shreg[7:1]};
         end
      end
   end

   // One-entry output buffer with overrun tracking and the frame error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= ferr_set;
         if (deliver) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            // Only an unconsumed old byte can be lost; a same-clock ack consumes it.
            if (rx_valid) begin
               rx_overrun <= ~rx_ack;
            end
         end else if (rx_valid && rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: drives 8N1 frames into uart_rx_deframer and checks the
// byte buffer against a transaction-level model of the receive buffer.
module tb_uart_rx_deframer;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD      = 100_000;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int LAT_NOM   = 2 + HALF_CLKS + 9 * BIT_CLKS;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  // Clock edge (counted from the start edge) on which a byte registers.
  localparam int DELIVER_EDGE = LAT_NOM + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // Buffer model: what the CPU should see between deliveries.
  logic       m_valid = 1'b0;
  logic       m_overrun = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       chk_en = 1'b0;
  int         ferr_seen = 0;
  logic [7:0] exp_q[$];

  uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk),
    .reset(reset),
    .UART_RX(UART_RX),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .rx_overrun(rx_overrun),
    .frame_err(frame_err),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests_run++;
    if (act < lo || act > hi) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (frame_err === 1'b1) ferr_seen++;
      if (chk_en) begin
        check("rx_valid", rx_valid, m_valid);
        check("rx_data", rx_data, m_data);
        check("rx_overrun", rx_overrun, m_overrun);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    if (m_valid) begin
      m_valid = 1'b0;
      m_overrun = 1'b0;
    end
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  function automatic logic line_bit(input logic [7:0] b, input logic stop, input int i);
    int bidx;
    bidx = i / BIT_CLKS;
    if (bidx == 0) return 1'b0;
    if (bidx <= 8) return b[bidx-1];
    return stop;
  endfunction

  // One full frame; ack_edge > 0 raises rx_ack for exactly that clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_edge);
    int   ferr0;
    int   lat;
    logic armed;
    logic [7:0] eb;
    ferr0 = ferr_seen;
    lat = -1;
    armed = stop && !m_valid;
    if (stop) exp_q.push_back(b);
    for (int i = 0; i < FRAME_CLKS; i++) begin
      @(negedge clk);
      if (armed && lat < 0 && rx_valid === 1'b1) lat = i;
      if (i == 80) check("busy_mid_frame", busy, 1);
      if (i == LAT_NOM - 4) chk_en = 1'b0;
      if (i == LAT_NOM + 4) begin
        check("frame_err_pulses", ferr_seen - ferr0, stop ? 0 : 1);
        if (stop) begin
          eb = exp_q.pop_front();
          if (m_valid) m_overrun = (ack_edge > 0) ? 1'b0 : 1'b1;
          m_valid = 1'b1;
          m_data = eb;
        end
        if (armed) check_range("deliver_latency", lat, LAT_NOM - 1, LAT_NOM + 1);
        chk_en = 1'b1;
      end
      UART_RX = line_bit(b, stop, i);
      rx_ack = (i + 1 == ack_edge);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(200_000 * 10);
    tests_failed++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int ferr0;
    logic [7:0] b;
    logic bad;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_overrun", rx_overrun, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(10);

    // 1: single byte
    send_frame(8'hA5, 1'b1, 0);
    check("t1_data", rx_data, 8'hA5);
    check("t1_valid", rx_valid, 1);
    check("t1_overrun", rx_overrun, 0);
    pulse_ack();
    check("t1_valid_after_ack", rx_valid, 0);
    check("t1_data_held", rx_data, 8'hA5);
    idle(10);

    // 2: short low glitch on an idle line
    ferr0 = ferr_seen;
    @(negedge clk); UART_RX = 1'b0;
    idle(2);
    @(negedge clk); UART_RX = 1'b1;
    idle(2);
    check("t2_busy_during_glitch", busy, 1);
    idle(20);
    check("t2_busy_after_glitch", busy, 0);
    check("t2_no_frame_err", ferr_seen - ferr0, 0);
    check("t2_valid", rx_valid, 0);

    // 3: bad stop bit, line held low, then a good byte
    send_frame(8'h3C, 1'b0, 0);
    check("t3_valid", rx_valid, 0);
    ferr0 = ferr_seen;
    idle(40);
    check("t3_busy_in_break", busy, 1);
    check("t3_no_retrigger", ferr_seen - ferr0, 0);
    UART_RX = 1'b1;
    idle(20);
    check("t3_busy_after_break", busy, 0);
    send_frame(8'h81, 1'b1, 0);
    check("t3_data", rx_data, 8'h81);
    check("t3_valid_good", rx_valid, 1);
    pulse_ack();
    idle(5);

    // 4: back-to-back bytes with no ack
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check("t4_data", rx_data, 8'h22);
    check("t4_overrun", rx_overrun, 1);
    check("t4_valid", rx_valid, 1);
    pulse_ack();
    check("t4_valid_after_ack", rx_valid, 0);
    check("t4_overrun_after_ack", rx_overrun, 0);
    idle(5);

    // 5: ack exactly in the delivery clock of a second byte
    send_frame(8'h77, 1'b1, 0);
    send_frame(8'h5A, 1'b1, DELIVER_EDGE);
    check("t5_valid", rx_valid, 1);
    check("t5_data", rx_data, 8'h5A);
    check("t5_overrun", rx_overrun, 0);
    pulse_ack();
    idle(5);

    // 6: reset while receiving data bit 4
    for (int i = 0; i < BIT_CLKS * 5 + HALF_CLKS; i++) begin
      @(negedge clk);
      UART_RX = line_bit(8'hC3, 1'b1, i);
    end
    check("t6_busy_before_reset", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    UART_RX = 1'b1;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_data = 8'h00;
    #1;
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_rx_overrun", rx_overrun, 0);
    check("t6_frame_err", frame_err, 0);
    check("t6_busy", busy, 0);
    idle(4);
    reset = 1'b0;
    idle(20);
    send_frame(8'hF0, 1'b1, 0);
    check("t6_data", rx_data, 8'hF0);
    check("t6_valid", rx_valid, 1);
    pulse_ack();
    idle(5);

    // random frames, gaps, acks and framing errors
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, ($urandom_range(0, 3) == 0) ? DELIVER_EDGE : 0);
      if (bad) begin
        idle($urandom_range(0, 20));
        UART_RX = 1'b1;
        idle(20);
        check("rand_busy_after_break", busy, 0);
      end else begin
        idle($urandom_range(0, 12));
      end
      if ($urandom_range(0, 1) == 1) pulse_ack();
    end

    idle(30);
    check("final_busy", busy, 0);
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
